radiance_recovery: RTL
======================

Name: radiance_recovery

Overview:
- Final stage of the saturation-based dehazing pipeline. Consumes the inverse transmission produced upstream (tran_inv, 12-bit) plus the hazy RGB pixel and atmospheric light A.
- Recovers scene radiance per channel as J = A + (I - A) * tinv, with clamping.
- Streams pixels with valid/ready and sof/eof sideband.
- Reports a per-frame count of clamped pixels.

Parameters:
PIX_W, 12, bits per colour channel (unsigned)
TINV_W, 12, width of inverse-transmission input (unsigned)
TINV_FRAC, 8, fractional bits of tinv (256 = 1.0)
TINV_MAX, 2048, saturation ceiling applied to tinv (8.0)
CNT_W, 21, width of clamp counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input beat valid
i_ready  out  1  input beat accepted when i_valid & i_ready
i_sof  in  1  first pixel of frame
i_eof  in  1  last pixel of frame
i_r, i_g, i_b  in  PIX_W each  hazy pixel
i_tinv  in  TINV_W  inverse transmission (UQ4.8)
a_r, a_g, a_b  in  PIX_W each  atmospheric light, sampled on accepted sof beat
o_valid  out  1  output beat valid
o_ready  in  1  downstream ready
o_sof, o_eof  out  1 each  sideband aligned with output pixel
o_r, o_g, o_b  out  PIX_W each  recovered pixel
clamp_cnt  out  CNT_W  clamped-pixel count of last completed frame
frame_done  out  1  one-cycle pulse when clamp_cnt updates

Behaviour:
- Reset asynchronous and active-low. Only clk is used: one clock.
- On reset assertion, clear immediately: all stage valids, o_valid, o_sof, o_eof, o_r/g/b, A registers, running counter, clamp_cnt and frame_done.
- Reset mid-frame discards all in-flight pixels. The first beat after reset must carry sof; until then A = 0.
- Pipeline is 3 stages, latency 3 accepted cycles from input beat to o_valid.
- Global advance enable: en = ~o_valid | o_ready. i_ready = en.
- When en = 0, every stage holds, and o_* stays stable while o_valid = 1.
- A capture: a_eff = i_sof ? a_* : A_reg on an accepted beat. A_reg <= a_* on an accepted sof beat. Non-sof beats use A_reg.
- Stage 1:
  - tinv_eff = 256 if i_tinv == 0 (no-transmission marker means pass-through); else min(i_tinv, TINV_MAX).
  - d_c = I_c - a_eff_c, signed PIX_W+1 bits.
  - Register d_c, a_eff_c, tinv_eff, sof, eof, valid.
- Stage 2:
  - p_c = d_c * tinv_eff, signed PIX_W+TINV_W+2 bits.
  - Register p_c, a_c, sideband, valid.
- Stage 3:
  - s_c = (p_c + 2^(TINV_FRAC-1)) >>> TINV_FRAC, arithmetic shift, round-half-up toward +inf.
  - j_c = s_c + a_c.
  - o_c = 0 if j_c < 0; 2^PIX_W - 1 if j_c > 2^PIX_W - 1; else j_c.
  - Pixel is "clamped" if any channel saturated.
- Clamp counter:
  - Updates only on output handshake (o_valid & o_ready).
  - Output beat with o_sof restarts the running count at 0 before adding the current pixel.
  - Add 1 if the pixel is clamped. The running count saturates at 2^CNT_W - 1.
  - On handshake with o_eof: clamp_cnt <= running count including this pixel; frame_done = 1 for exactly one cycle.
  - sof and eof on the same beat (1-pixel frame): count is 0 or 1, latched the same cycle.
- Bubbles:
  - Empty stages propagate invalid. An invalid stage never changes counters or A_reg.
  - Stage 1 of an idle pipeline still fills when en = 1.

Decomposition:
- Shared package dehaze_pkg: PIX_W, TINV_W, TINV_FRAC, TINV_ONE (256), TINV_MAX constants; a pixel struct {r, g, b} typedef.
- One sub-module: recover_channel. It implements the per-channel diff/multiply/round/add/clamp datapath with stage registers and en input, emitting o_c and a clamp flag. It is instantiated 3x. The top holds the handshake, sideband pipe, A_reg and counters.

Test Plan:
- A=(1000,1000,1000), I=(2000,2000,2000), tinv=384, o_ready=1 -> o=(2500,2500,2500) exactly 3 cycles after accept; clamp_cnt unchanged.
- A=3000, I=1000, tinv=512 -> j = -1000, o=0. A=1000, I=4000, tinv=512 -> j = 7000, o=4095. Both count as clamped; a 2-pixel frame gives clamp_cnt=2 and a frame_done pulse.
- tinv=0 with I=1234, A=3000 -> o=1234 (pass-through). tinv=4095 -> treated as 2048.
- o_ready low for 5 cycles with 3 beats in flight -> i_ready=0 throughout, o_* stable, no loss or duplication; order preserved after release.
- Frame 1 A=500, frame 2 sof carries A=2000 on the same beat as the pixel -> that pixel uses 2000; next non-sof beat also uses 2000, even if a_* changes.
- Assert rst_n low mid-frame with 3 pixels in flight -> o_valid=0 asynchronously, clamp_cnt=0; no output from the discarded pixels after release.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared constants and types for the dehazing pipeline's radiance recovery stage.
package dehaze_pkg;

  localparam int unsigned PIX_W     = 12;
  localparam int unsigned TINV_W    = 12;
  localparam int unsigned TINV_FRAC = 8;
  localparam int unsigned TINV_ONE  = 256;
  localparam int unsigned TINV_MAX  = 2048;
  localparam int unsigned CNT_W     = 21;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

  // Zero marks "no transmission estimate": treat as unity gain.
  function automatic logic [TINV_W-1:0] tinv_limit(input logic [TINV_W-1:0] t);
    if (t == '0) begin
      return TINV_W'(TINV_ONE);
    end else if (t > TINV_W'(TINV_MAX)) begin
      return TINV_W'(TINV_MAX);
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/radiance_recovery_if.sv
// Pixel stream bundle: input beat with atmospheric light, output recovered beat.
interface radiance_recovery_if;
  import dehaze_pkg::*;

  logic              i_valid;
  logic              i_ready;
  logic              i_sof;
  logic              i_eof;
  logic [PIX_W-1:0]  i_r;
  logic [PIX_W-1:0]  i_g;
  logic [PIX_W-1:0]  i_b;
  logic [TINV_W-1:0] i_tinv;
  logic [PIX_W-1:0]  a_r;
  logic [PIX_W-1:0]  a_g;
  logic [PIX_W-1:0]  a_b;
  logic              o_valid;
  logic              o_ready;
  logic              o_sof;
  logic              o_eof;
  logic [PIX_W-1:0]  o_r;
  logic [PIX_W-1:0]  o_g;
  logic [PIX_W-1:0]  o_b;

  modport master (
    output i_valid, i_sof, i_eof, i_r, i_g, i_b, i_tinv, a_r, a_g, a_b, o_ready,
    input  i_ready, o_valid, o_sof, o_eof, o_r, o_g, o_b
  );

  modport slave (
    input  i_valid, i_sof, i_eof, i_r, i_g, i_b, i_tinv, a_r, a_g, a_b, o_ready,
    output i_ready, o_valid, o_sof, o_eof, o_r, o_g, o_b
  );

endinterface

// File: rtl/recover_channel.sv
// One colour channel of J = A + (I - A) * tinv: diff, multiply, round/add/clamp stages.
module recover_channel
  import dehaze_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [PIX_W-1:0]  pix,
  input  logic [PIX_W-1:0]  a,
  input  logic [TINV_W-1:0] tinv,
  output logic [PIX_W-1:0]  o_c,
  output logic              clamp
);

  localparam int unsigned DW = PIX_W + 1;
  localparam int unsigned PW = PIX_W + TINV_W + 2;
  localparam logic signed [PW-1:0] Half   = PW'(1 << (TINV_FRAC - 1));
  localparam logic signed [PW-1:0] PixMax = PW'((1 << PIX_W) - 1);

  logic signed [DW-1:0] d_q;
  logic [PIX_W-1:0]     a1_q;
  logic [PIX_W-1:0]     a2_q;
  logic [TINV_W-1:0]    t_q;
  logic signed [PW-1:0] p_q;

  logic signed [DW-1:0] d;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] j;
  logic [PIX_W-1:0]     o_d;
  logic                 clamp_d;

  always_comb begin
    d = $signed({1'b0, pix}) - $signed({1'b0, a});
    p = PW'(d_q) * $signed(PW'({1'b0, t_q}));
    // Arithmetic shift after adding half rounds ties toward +inf.
    j = ((p_q + Half) >>> TINV_FRAC) + $signed(PW'({1'b0, a2_q}));
    o_d     = j[PIX_W-1:0];
    clamp_d = 1'b0;
    if (j < 0) begin
      o_d     = '0;
      clamp_d = 1'b1;
    end else if (j > PixMax) begin
      o_d     = '1;
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      a1_q  <= '0;
      t_q   <= '0;
      p_q   <= '0;
      a2_q  <= '0;
      o_c   <= '0;
      clamp <= 1'b0;
    end else if (en) begin
      d_q   <= d;
      a1_q  <= a;
      t_q   <= tinv;
      p_q   <= p;
      a2_q  <= a1_q;
      o_c   <= o_d;
      clamp <= clamp_d;
    end
  end

endmodule

// File: rtl/radiance_recovery.sv
// Radiance recovery top: stream handshake, sideband pipe, atmospheric light and clamp counter.
module radiance_recovery
  import dehaze_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  radiance_recovery_if.slave   bus,
  output logic [CNT_W-1:0]     clamp_cnt,
  output logic                 frame_done
);

  logic              en;
  logic              acc;
  logic              hs;
  pixel_t            a_q;
  pixel_t            a_eff;
  logic [TINV_W-1:0] tinv_eff;
  logic              v1_q, v2_q, sof1_q, sof2_q, eof1_q, eof2_q;
  logic              clamp_r, clamp_g, clamp_b, clamp_px;
  logic [CNT_W-1:0]  run_q, run_d, base;

  assign en          = ~bus.o_valid | bus.o_ready;
  assign bus.i_ready = en;
  assign acc         = bus.i_valid & en;
  assign hs          = bus.o_valid & bus.o_ready;
  assign tinv_eff    = tinv_limit(bus.i_tinv);
  assign clamp_px    = clamp_r | clamp_g | clamp_b;

  // A sof beat carries its own atmospheric light; later beats reuse the latched one.
  always_comb begin
    a_eff = a_q;
    if (bus.i_sof) a_eff = '{r: bus.a_r, g: bus.a_g, b: bus.a_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
    end else if (acc && bus.i_sof) begin
      a_q <= a_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      sof1_q      <= 1'b0;
      sof2_q      <= 1'b0;
      eof1_q      <= 1'b0;
      eof2_q      <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_sof   <= 1'b0;
      bus.o_eof   <= 1'b0;
    end else if (en) begin
      v1_q        <= bus.i_valid;
      sof1_q      <= bus.i_valid & bus.i_sof;
      eof1_q      <= bus.i_valid & bus.i_eof;
      v2_q        <= v1_q;
      sof2_q      <= sof1_q;
      eof2_q      <= eof1_q;
      bus.o_valid <= v2_q;
      bus.o_sof   <= sof2_q;
      bus.o_eof   <= eof2_q;
    end
  end

  recover_channel u_ch_r (
    .clk(clk), .rst_n(rst_n), .en(en), .pix(bus.i_r), .a(a_eff.r), .tinv(tinv_eff),
    .o_c(bus.o_r), .clamp(clamp_r)
  );

  recover_channel u_ch_g (
    .clk(clk), .rst_n(rst_n), .en(en), .pix(bus.i_g), .a(a_eff.g), .tinv(tinv_eff),
    .o_c(bus.o_g), .clamp(clamp_g)
  );

  recover_channel u_ch_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pix(bus.i_b), .a(a_eff.b), .tinv(tinv_eff),
    .o_c(bus.o_b), .clamp(clamp_b)
  );

  always_comb begin
    base  = bus.o_sof ? '0 : run_q;
    run_d = (&base) ? base : base + CNT_W'(clamp_px);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= '0;
      clamp_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs & bus.o_eof;
      if (hs) run_q <= run_d;
      if (hs && bus.o_eof) clamp_cnt <= run_d;
    end
  end

endmodule
